// File: rtl/sequenciador_entrada_ula.sv
// sequenciador_entrada_ula: button-driven A/B/opcode entry sequencer for the ALU; define DEBOUNCE_EN to add per-button debounce
module sequenciador_entrada_ula #(
  parameter int LARGURA         = 8,
  parameter int LARGURA_OP      = 3,
  parameter int LATENCIA_ULA    = 1,
  parameter int DEBOUNCE_CICLOS = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [LARGURA-1:0]    chaves,
  input  logic                  botao_confirma_n,
  input  logic                  botao_volta_n,
  input  logic [LARGURA-1:0]    resultado_ula,
  input  logic [3:0]            flags_ula,
  output logic [LARGURA-1:0]    operando_a,
  output logic [LARGURA-1:0]    operando_b,
  output logic [LARGURA_OP-1:0] opcode,
  output logic                  ula_inicia,
  output logic [LARGURA-1:0]    resultado_reg,
  output logic [3:0]            flags_reg,
  output logic [2:0]            estado,
  output logic                  pronto
);
  localparam logic [2:0] ESPERA_A  = 3'd0;
  localparam logic [2:0] ESPERA_B  = 3'd1;
  localparam logic [2:0] ESPERA_OP = 3'd2;
  localparam logic [2:0] EXECUTA   = 3'd3;
  localparam logic [2:0] MOSTRA    = 3'd4;
  logic [1:0] sinc1_q, pulso;
  logic confirma, volta, fim;
  logic [2:0] estado_q, estado_d;
  logic [3:0] cont_q, cont_d;
  logic [LARGURA-1:0] op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic [LARGURA_OP-1:0] opcode_q, opcode_d;
  logic [3:0] flags_q, flags_d;
  logic inicia_q, inicia_d, pronto_q, pronto_d;
  // first synchronizer stage, bit 0 = confirm, bit 1 = back
  always_ff @(posedge clk)
    if (!reset_n) sinc1_q <= 2'b11;
    else sinc1_q <= {botao_volta_n, botao_confirma_n};
`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  logic [1:0] nivel_q, nivel_ant_q;
  logic [CW-1:0] cont_db_q [2];
  // accepted level follows stage 1 only after DEBOUNCE_CICLOS consecutive differing samples
  always_ff @(posedge clk)
    if (!reset_n) begin
      nivel_q <= 2'b11;
      nivel_ant_q <= 2'b11;
      for (int i = 0; i < 2; i++) cont_db_q[i] <= '0;
    end else begin
      nivel_ant_q <= nivel_q;
      for (int i = 0; i < 2; i++)
        if (sinc1_q[i] == nivel_q[i]) cont_db_q[i] <= '0;
        else if (cont_db_q[i] == CW'(DEBOUNCE_CICLOS - 1)) begin
          nivel_q[i] <= sinc1_q[i];
          cont_db_q[i] <= '0;
        end else cont_db_q[i] <= cont_db_q[i] + 1'b1;
    end
  assign pulso = nivel_ant_q & ~nivel_q;
`else
  logic [1:0] sinc2_q;
  // second synchronizer stage; its lag behind stage 1 exposes the falling edge
  always_ff @(posedge clk)
    if (!reset_n) sinc2_q <= 2'b11;
    else sinc2_q <= sinc1_q;
  assign pulso = sinc2_q & ~sinc1_q;
`endif
  assign volta    = pulso[1];
  assign confirma = pulso[0] & ~pulso[1];
  assign fim      = (estado_q == EXECUTA) && (cont_q == 4'(LATENCIA_ULA - 1));
  // state and datapath registers
  always_ff @(posedge clk)
    if (!reset_n) begin
      estado_q <= ESPERA_A;
      cont_q   <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opcode_q <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      inicia_q <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      opcode_q <= opcode_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      inicia_q <= inicia_d;
      pronto_q <= pronto_d;
    end
  // next state: back beats confirm; pulses in EXECUTA are dropped
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ESPERA_A:  estado_d = confirma ? ESPERA_B : ESPERA_A;
      ESPERA_B:  estado_d = volta ? ESPERA_A : confirma ? ESPERA_OP : ESPERA_B;
      ESPERA_OP: estado_d = volta ? ESPERA_B : confirma ? EXECUTA : ESPERA_OP;
      EXECUTA:   estado_d = fim ? MOSTRA : EXECUTA;
      MOSTRA:    estado_d = volta ? ESPERA_OP : confirma ? ESPERA_A : MOSTRA;
      default:   estado_d = ESPERA_A;
    endcase
  end
  // register loads: captures on accepted confirm, result capture at end of latency
  always_comb begin
    op_a_d   = (estado_q == ESPERA_A && confirma) ? chaves : op_a_q;
    op_b_d   = (estado_q == ESPERA_B && confirma) ? chaves : op_b_q;
    opcode_d = (estado_q == ESPERA_OP && confirma) ? chaves[LARGURA_OP-1:0] : opcode_q;
    res_d    = fim ? resultado_ula : res_q;
    flags_d  = fim ? flags_ula : flags_q;
    cont_d   = (estado_q == EXECUTA) ? cont_q + 4'd1 : 4'd0;
    inicia_d = (estado_d == EXECUTA) && (estado_q != EXECUTA);
    pronto_d = (estado_d == MOSTRA);
  end
  assign operando_a    = op_a_q;
  assign operando_b    = op_b_q;
  assign opcode        = opcode_q;
  assign ula_inicia    = inicia_q;
  assign resultado_reg = res_q;
  assign flags_reg     = flags_q;
  assign estado        = estado_q;
  assign pronto        = pronto_q;
endmodule
